caliptra_fpga_sync_bkpt_ctrl: RTL

- Breakpoint controller in the gated-clock domain of the FPGA sync block.
- Watches the free-running gated cycle counter and DUT trigger lines, and raises a halt request so the clock-gating controller stops stepping the gated clock at an exact, reproducible cycle.
- Captures the cycle number and trigger vector at the hit, for readback through the sync register block.
- All state advances only on gated edges, so behaviour is deterministic with respect to the stepped cycle count.

---
 rtl/caliptra_fpga_sync_bkpt_ctrl_if.sv | 34 +++
 rtl/caliptra_fpga_sync_bkpt_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/caliptra_fpga_sync_bkpt_ctrl_if.sv
// Configuration, trigger and status bundle for the gated-domain breakpoint controller.
// Handshake: no valid/ready pair; config and triggers are level-sampled on every gated edge, halt_req is a registered level held while state==HALT.
interface caliptra_fpga_sync_bkpt_ctrl_if #(
  parameter int NUM_TRIG = 4,
  parameter int CNT_W    = 64,
  parameter int DLY_W    = 16
);
  logic                cfg_arm;
  logic                cfg_disarm;
  logic [1:0]          cfg_mode;
  logic [CNT_W-1:0]    cfg_cycle_target;
  logic [NUM_TRIG-1:0] cfg_trig_mask;
  logic [7:0]          cfg_hit_target;
  logic [DLY_W-1:0]    cfg_post_delay;
  logic [CNT_W-1:0]    cycle_count;
  logic [NUM_TRIG-1:0] trig_in;
  logic                halt_req;
  logic [1:0]          state;
  logic [7:0]          hit_count;
  logic [CNT_W-1:0]    cycle_capture;
  logic [NUM_TRIG-1:0] trig_capture;

  modport master (
    output cfg_arm, cfg_disarm, cfg_mode, cfg_cycle_target, cfg_trig_mask,
           cfg_hit_target, cfg_post_delay, cycle_count, trig_in,
    input  halt_req, state, hit_count, cycle_capture, trig_capture
  );

  modport slave (
    input  cfg_arm, cfg_disarm, cfg_mode, cfg_cycle_target, cfg_trig_mask,
           cfg_hit_target, cfg_post_delay, cycle_count, trig_in,
    output halt_req, state, hit_count, cycle_capture, trig_capture
  );
endinterface

// File: rtl/caliptra_fpga_sync_bkpt_ctrl.sv
// Breakpoint controller: counts cycle/trigger matches on gated edges and raises halt_req
// at a reproducible cycle, capturing cycle number and trigger vector at the firing match.
module caliptra_fpga_sync_bkpt_ctrl #(
  parameter int NUM_TRIG = 4,
  parameter int CNT_W    = 64,
  parameter int DLY_W    = 16
) (
  input  logic aclk_gated,
  input  logic rstn,
  caliptra_fpga_sync_bkpt_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DELAY = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_TRIG-1:0] prev_trig_q;
  logic                prev_all_q;
  logic [DLY_W-1:0]    dly_q, dly_d;
  logic [7:0]          hit_q, hit_d;
  logic [CNT_W-1:0]    cyc_cap_q, cyc_cap_d;
  logic [NUM_TRIG-1:0] trig_cap_q, trig_cap_d;
  logic                halt_q;

  logic [NUM_TRIG-1:0] trig_edge;
  logic                all_cond;
  logic                match;
  logic [7:0]          hit_inc;
  logic [7:0]          hit_tgt;
  logic                fire;

  // An empty mask would make the all-of condition vacuously true, so it is forced low.
  always_comb begin
    trig_edge = bus.trig_in & ~prev_trig_q;
    all_cond  = (|bus.cfg_trig_mask) & (&(bus.trig_in | ~bus.cfg_trig_mask));
    match     = 1'b0;
    case (bus.cfg_mode)
      2'd0:    match = (bus.cycle_count == bus.cfg_cycle_target);
      2'd1:    match = |(trig_edge & bus.cfg_trig_mask);
      2'd2:    match = all_cond & ~prev_all_q;
      default: match = 1'b0;
    endcase
    hit_inc = (hit_q == 8'hFF) ? hit_q : hit_q + 8'd1;
    hit_tgt = (bus.cfg_hit_target == 8'd0) ? 8'd1 : bus.cfg_hit_target;
    fire    = (hit_inc >= hit_tgt);
  end

  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    hit_d      = hit_q;
    cyc_cap_d  = cyc_cap_q;
    trig_cap_d = trig_cap_q;
    if (bus.cfg_disarm) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.cfg_arm) begin
            state_d    = ST_ARMED;
            hit_d      = 8'd0;
            cyc_cap_d  = '0;
            trig_cap_d = '0;
          end
        end
        ST_ARMED: begin
          if (match) begin
            hit_d = hit_inc;
            if (fire) begin
              cyc_cap_d  = bus.cycle_count;
              trig_cap_d = bus.trig_in;
              if (bus.cfg_post_delay == '0) begin
                state_d = ST_HALT;
              end else begin
                state_d = ST_DELAY;
                dly_d   = bus.cfg_post_delay - DLY_W'(1);
              end
            end
          end
        end
        ST_DELAY: begin
          if (dly_q == '0) state_d = ST_HALT;
          else             dly_d   = dly_q - DLY_W'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk_gated or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      prev_trig_q <= '0;
      prev_all_q  <= 1'b0;
      dly_q       <= '0;
      hit_q       <= 8'd0;
      cyc_cap_q   <= '0;
      trig_cap_q  <= '0;
      halt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_trig_q <= bus.trig_in;
      prev_all_q  <= all_cond;
      dly_q       <= dly_d;
      hit_q       <= hit_d;
      cyc_cap_q   <= cyc_cap_d;
      trig_cap_q  <= trig_cap_d;
      halt_q      <= (state_d == ST_HALT);
    end
  end

  assign bus.halt_req      = halt_q;
  assign bus.state         = state_q;
  assign bus.hit_count     = hit_q;
  assign bus.cycle_capture = cyc_cap_q;
  assign bus.trig_capture  = trig_cap_q;

endmodule
